branch_resolve_unit: RTL and testbench

//   Write side of the branch target buffer. Holds fetch-time predictions in order

---
 rtl/bru_pkg.sv | 13 +
 rtl/branch_resolve_unit_if.sv | 42 ++++
 rtl/bru_pred_fifo.sv | 58 +++++
 rtl/branch_resolve_unit.sv | 97 +++++++++
 tb/tb_branch_resolve_unit.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/bru_pkg.sv
// rtl/bru_pkg.sv - shared types and constants for the branch resolve unit
package bru_pkg;

  localparam int ADDR_W      = 32;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic              hit;
    logic [ADDR_W-1:0] target;
  } pred_entry_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// rtl/branch_resolve_unit_if.sv - fetch/execute/BTB handshake bundle of the branch resolve unit
interface branch_resolve_unit_if #(
  parameter int ADDR_W = bru_pkg::ADDR_W
);

  logic              pred_valid;
  logic              pred_ready;
  logic [ADDR_W-1:0] pred_pc;
  logic              pred_hit;
  logic [ADDR_W-1:0] pred_target;

  logic              res_valid;
  logic              res_ready;
  logic              res_taken;
  logic [ADDR_W-1:0] res_target;

  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_set;

  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              err_underflow;

  modport master (
    output pred_valid, pred_pc, pred_hit, pred_target,
    output res_valid, res_taken, res_target,
    input  pred_ready, res_ready,
    input  upd_valid, upd_pc, upd_target, upd_set,
    input  redirect_valid, redirect_pc, err_underflow
  );

  modport slave (
    input  pred_valid, pred_pc, pred_hit, pred_target,
    input  res_valid, res_taken, res_target,
    output pred_ready, res_ready,
    output upd_valid, upd_pc, upd_target, upd_set,
    output redirect_valid, redirect_pc, err_underflow
  );

endinterface

// File: rtl/bru_pred_fifo.sv
// rtl/bru_pred_fifo.sv - in-order queue of fetch-time predictions awaiting resolution
module bru_pred_fifo
  import bru_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push_i,
  input  pred_entry_t push_data_i,
  input  logic        pop_i,
  input  logic        flush_i,
  output logic        full_o,
  output logic        empty_o,
  output pred_entry_t head_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  pred_entry_t      mem_q [DEPTH];

  logic do_push, do_pop;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // full/empty are registered, so a pop in the same cycle never frees room for a push
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - resolves queued predictions, drives BTB updates and redirects
// Optional BRU_STATS_EN adds resolution/mispredict counters.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = bru_pkg::ADDR_W
) (
  input  logic                 clk,
  input  logic                 reset,
  branch_resolve_unit_if.slave bus
`ifdef BRU_STATS_EN
  ,
  output logic [31:0]          stat_resolved_o,
  output logic [31:0]          stat_mispredict_o
`endif
);

  pred_entry_t push_entry, head;
  logic        fifo_full, fifo_empty;
  logic        accept, mispredict, tgt_differs, upd_needed;

  logic              upd_valid_q, upd_set_q, redirect_valid_q, err_underflow_q;
  logic [ADDR_W-1:0] upd_pc_q, upd_target_q, redirect_pc_q;

  assign push_entry.pc     = bus.pred_pc;
  assign push_entry.hit    = bus.pred_hit;
  assign push_entry.target = bus.pred_target;

  assign accept      = bus.res_valid && !fifo_empty;
  assign tgt_differs = (head.target != bus.res_target);
  assign mispredict  = (head.hit != bus.res_taken) || (head.hit && bus.res_taken && tgt_differs);
  // Not-taken and not in the BTB leaves the BTB alone; a correct taken hit needs no rewrite
  assign upd_needed  = bus.res_taken ? (!head.hit || tgt_differs) : head.hit;

  bru_pred_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (bus.pred_valid),
    .push_data_i (push_entry),
    .pop_i       (bus.res_valid),
    .flush_i     (accept && mispredict),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (head)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upd_valid_q      <= 1'b0;
      upd_set_q        <= 1'b0;
      upd_pc_q         <= '0;
      upd_target_q     <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      err_underflow_q  <= 1'b0;
    end else begin
      upd_valid_q      <= accept && upd_needed;
      redirect_valid_q <= accept && mispredict;
      if (bus.res_valid && fifo_empty) err_underflow_q <= 1'b1;
      if (accept) begin
        upd_pc_q      <= head.pc;
        upd_set_q     <= bus.res_taken;
        upd_target_q  <= bus.res_taken ? bus.res_target : head.target;
        redirect_pc_q <= bus.res_taken ? bus.res_target : head.pc + ADDR_W'(INSTR_BYTES);
      end
    end
  end

`ifdef BRU_STATS_EN
  logic [31:0] stat_resolved_q, stat_mispredict_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_resolved_q   <= '0;
      stat_mispredict_q <= '0;
    end else if (accept) begin
      stat_resolved_q <= stat_resolved_q + 32'd1;
      if (mispredict) stat_mispredict_q <= stat_mispredict_q + 32'd1;
    end
  end

  assign stat_resolved_o   = stat_resolved_q;
  assign stat_mispredict_o = stat_mispredict_q;
`endif

  assign bus.pred_ready     = !fifo_full;
  assign bus.res_ready      = !fifo_empty;
  assign bus.upd_valid      = upd_valid_q;
  assign bus.upd_set        = upd_set_q;
  assign bus.upd_pc         = upd_pc_q;
  assign bus.upd_target     = upd_target_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.err_underflow  = err_underflow_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed vector bench for branch_resolve_unit
module tb_branch_resolve_unit;

  logic clk = 1'b0;
  logic reset;

  branch_resolve_unit_if #(.ADDR_W(32)) bus ();

  branch_resolve_unit #(.DEPTH(8), .ADDR_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic        hit;
    logic [31:0] tgt;
    logic        taken;
    logic [31:0] res_tgt;
    logic        e_upd;
    logic        e_set;
    logic [31:0] e_upd_tgt;
    logic        e_redir;
    logic [31:0] e_redir_pc;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // All tasks start and end at a falling edge
  task automatic push_entry(logic [31:0] pc, logic hit, logic [31:0] tgt);
    bus.pred_valid  = 1'b1;
    bus.pred_pc     = pc;
    bus.pred_hit    = hit;
    bus.pred_target = tgt;
    @(negedge clk);
    bus.pred_valid  = 1'b0;
  endtask

  task automatic resolve(logic taken, logic [31:0] tgt);
    bus.res_valid  = 1'b1;
    bus.res_taken  = taken;
    bus.res_target = tgt;
    @(negedge clk);
    bus.res_valid  = 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'h100, 1'b0, 32'h0,   1'b1, 32'h200, 1'b1, 1'b1, 32'h200, 1'b1, 32'h200};
    vecs[1] = '{32'h300, 1'b1, 32'h400, 1'b1, 32'h400, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0};
    vecs[2] = '{32'h500, 1'b1, 32'h600, 1'b1, 32'h700, 1'b1, 1'b1, 32'h700, 1'b1, 32'h700};
    vecs[3] = '{32'h800, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 32'h0};
    vecs[4] = '{32'hFFFF_FFFC, 1'b1, 32'h10, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0000};
    vecs[5] = '{32'h900, 1'b1, 32'hA00, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 32'h904};

    reset = 1'b1;
    bus.pred_valid = 1'b0; bus.pred_pc = '0; bus.pred_hit = 1'b0; bus.pred_target = '0;
    bus.res_valid  = 1'b0; bus.res_taken = 1'b0; bus.res_target = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    chk("reset pred_ready", 32'(bus.pred_ready), 32'd1);
    chk("reset res_ready", 32'(bus.res_ready), 32'd0);
    chk("reset upd_valid", 32'(bus.upd_valid), 32'd0);
    chk("reset redirect_valid", 32'(bus.redirect_valid), 32'd0);
    chk("reset err_underflow", 32'(bus.err_underflow), 32'd0);

    for (int i = 0; i < 6; i++) begin
      push_entry(vecs[i].pc, vecs[i].hit, vecs[i].tgt);
      resolve(vecs[i].taken, vecs[i].res_tgt);
      chk($sformatf("vec%0d upd_valid", i), 32'(bus.upd_valid), 32'(vecs[i].e_upd));
      chk($sformatf("vec%0d redirect_valid", i), 32'(bus.redirect_valid), 32'(vecs[i].e_redir));
      if (vecs[i].e_upd) begin
        chk($sformatf("vec%0d upd_pc", i), bus.upd_pc, vecs[i].pc);
        chk($sformatf("vec%0d upd_set", i), 32'(bus.upd_set), 32'(vecs[i].e_set));
        if (vecs[i].e_set) chk($sformatf("vec%0d upd_target", i), bus.upd_target, vecs[i].e_upd_tgt);
      end
      if (vecs[i].e_redir) chk($sformatf("vec%0d redirect_pc", i), bus.redirect_pc, vecs[i].e_redir_pc);
      chk($sformatf("vec%0d res_ready", i), 32'(bus.res_ready), 32'd0);
      @(negedge clk);
      chk($sformatf("vec%0d strobe drop", i), 32'(bus.upd_valid | bus.redirect_valid), 32'd0);
    end

    // Mispredict flushes younger entries, including one pushed on the resolve edge
    push_entry(32'h40, 1'b1, 32'h80);
    push_entry(32'h50, 1'b0, 32'h0);
    push_entry(32'h60, 1'b0, 32'h0);
    push_entry(32'h70, 1'b0, 32'h0);
    bus.pred_valid = 1'b1; bus.pred_pc = 32'h90; bus.pred_hit = 1'b0;
    resolve(1'b0, 32'h0);
    bus.pred_valid = 1'b0;
    chk("flush upd_valid", 32'(bus.upd_valid), 32'd1);
    chk("flush upd_set", 32'(bus.upd_set), 32'd0);
    chk("flush upd_pc", bus.upd_pc, 32'h40);
    chk("flush redirect_pc", bus.redirect_pc, 32'h44);
    chk("flush res_ready", 32'(bus.res_ready), 32'd0);

    // Fill, then pop+push in one cycle: the push must be rejected
    for (int i = 0; i < 8; i++) push_entry(32'h1000 + 32'(i) * 4, 1'b0, 32'h0);
    chk("full pred_ready", 32'(bus.pred_ready), 32'd0);
    bus.pred_valid = 1'b1; bus.pred_pc = 32'hDEAD_0000; bus.pred_hit = 1'b1; bus.pred_target = 32'h1;
    resolve(1'b0, 32'h0);
    bus.pred_valid = 1'b0;
    chk("full popped pred_ready", 32'(bus.pred_ready), 32'd1);
    for (int i = 0; i < 7; i++) begin
      resolve(1'b0, 32'h0);
      chk($sformatf("drain%0d redirect", i), 32'(bus.redirect_valid | bus.upd_valid), 32'd0);
    end
    chk("drain res_ready", 32'(bus.res_ready), 32'd0);

    for (int i = 0; i < 20; i++) begin
      push_entry(32'h2000 + 32'(i) * 8, 1'b1, 32'h3000 + 32'(i) * 16);
      resolve(1'b1, 32'h3000 + 32'(i) * 16);
      chk($sformatf("wrap%0d strobes", i), 32'(bus.redirect_valid | bus.upd_valid), 32'd0);
    end

    // Underflow is sticky until reset
    resolve(1'b1, 32'h123);
    chk("underflow err", 32'(bus.err_underflow), 32'd1);
    chk("underflow strobes", 32'(bus.redirect_valid | bus.upd_valid), 32'd0);
    push_entry(32'h700, 1'b0, 32'h0);
    resolve(1'b0, 32'h0);
    chk("underflow sticky", 32'(bus.err_underflow), 32'd1);

    // Asynchronous reset mid-operation
    push_entry(32'hA0, 1'b1, 32'hB0);
    push_entry(32'hC0, 1'b1, 32'hD0);
    reset = 1'b1;
    #1;
    chk("async reset res_ready", 32'(bus.res_ready), 32'd0);
    chk("async reset err", 32'(bus.err_underflow), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    chk("post reset pred_ready", 32'(bus.pred_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
